// File: rtl/thermal_update_sched.sv
// Sequences NUM_CH thermal-model instances from one prescaled tick: per channel it
// computes the steady-state target, pulses that channel's update, then checks its alarm.
module thermal_update_sched #(
  parameter int WIDTH    = 16,
  parameter int NUM_CH   = 4,
  parameter int PWR_W    = 8,
  parameter int RTH_FRAC = 4,
  parameter int DIV_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [DIV_W-1:0]        cfg_period,
  input  logic [WIDTH-1:0]        t_amb,
  input  logic [WIDTH-1:0]        r_th,
  input  logic [WIDTH-1:0]        t_hi,
  input  logic [WIDTH-1:0]        t_lo,
  input  logic [NUM_CH*PWR_W-1:0] power,
  input  logic [NUM_CH*WIDTH-1:0] t_cur,
  output logic [WIDTH-1:0]        t_steady,
  output logic [NUM_CH-1:0]       upd_en,
  output logic [NUM_CH-1:0]       alarm,
  output logic                    busy,
  output logic                    overrun,
  output logic                    sweep_done
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PROD_W = PWR_W + WIDTH;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_ISSUE, S_CHECK} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DIV_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    t_steady_q, t_steady_d;
  logic [NUM_CH-1:0]   upd_en_q, upd_en_d;
  logic [NUM_CH-1:0]   alarm_q, alarm_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                sweep_done_q, sweep_done_d;

  logic                tick;
  logic [PWR_W-1:0]    pwr_sel;
  logic [PROD_W-1:0]   prod;
  logic [PROD_W:0]     sum;
  logic [WIDTH-1:0]    sum_sat;
  logic [WIDTH-1:0]    t_sel;

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    tick  = 1'b0;
    cnt_d = '0;
    if (enable) begin
      if (cnt_q == cfg_period) tick = 1'b1;
      else                     cnt_d = cnt_q + 1'b1;
    end

    pwr_sel = power[ch_q*PWR_W +: PWR_W];
    prod    = PROD_W'(pwr_sel) * PROD_W'(r_th);
    sum     = (PROD_W+1)'(t_amb) + (PROD_W+1)'(prod >> RTH_FRAC);
    sum_sat = (|sum[PROD_W:WIDTH]) ? '1 : sum[WIDTH-1:0];
    t_sel   = t_cur[ch_q*WIDTH +: WIDTH];

    state_d      = state_q;
    ch_d         = ch_q;
    t_steady_d   = t_steady_q;
    upd_en_d     = '0;
    alarm_d      = alarm_q;
    busy_d       = busy_q;
    sweep_done_d = 1'b0;
    // A tick seen in any non-idle state is dropped, including the sweep_done cycle.
    overrun_d    = overrun_q | (tick && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_CALC;
          ch_d    = '0;
          busy_d  = 1'b1;
        end
      end
      S_CALC: begin
        t_steady_d = sum_sat;
        upd_en_d   = NUM_CH'(1) << ch_q;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        sweep_done_d = (ch_q == LAST_CH);
        state_d      = S_CHECK;
      end
      S_CHECK: begin
        if (t_sel >= t_hi)     alarm_d[ch_q] = 1'b1;
        else if (t_sel < t_lo) alarm_d[ch_q] = 1'b0;
        if (ch_q == LAST_CH) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_CALC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      cnt_q        <= '0;
      t_steady_q   <= '0;
      upd_en_q     <= '0;
      alarm_q      <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      t_steady_q   <= t_steady_d;
      upd_en_q     <= upd_en_d;
      alarm_q      <= alarm_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign t_steady   = t_steady_q;
  assign upd_en     = upd_en_q;
  assign alarm      = alarm_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;
  assign sweep_done = sweep_done_q;

endmodule
